// File: rtl/rmap_wb_arbiter.sv
// rmap_wb_arbiter
//
// Two-master Wishbone arbiter that shares one slave bus between the RMAP
// target engine (master 0) and a local host port (master 1). Ownership is
// decided round-robin once per bus cycle: a granted master keeps the bus
// until it drops cyc, and a handover always passes through one cycle in
// which the slave sees cycOut low.
//
// Parameters
//   BUS_WIDTH       data width in bits (multiple of 8)
//   TIMEOUT_CYCLES  watchdog limit in clocks (1..65535)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m0*In / m0*Out           RMAP master: cyc, stb, we, adr, sel, dat / ack, err, dat
//   m1*In / m1*Out           host master, same set as m0
//   cycOut..datOut           slave request side
//   datIn, ackIn, errIn      slave response side
//   grant                    one-hot current owner, 00 when idle
//   timeoutFlag              one-cycle pulse when the watchdog fires
//
// Optional feature
//   RMAP_WB_ARB_TIMEOUT_EN   when defined, a stalled access (stb high with no
//                            ack/err) is terminated with err after
//                            TIMEOUT_CYCLES clocks. When undefined, no
//                            watchdog exists and timeoutFlag is tied low.

module rmap_wb_arbiter #(
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0CycIn,
    input  logic                   m0StbIn,
    input  logic                   m0WeIn,
    input  logic [31:0]            m0AdrIn,
    input  logic [BUS_WIDTH/8-1:0] m0SelIn,
    input  logic [BUS_WIDTH-1:0]   m0DatIn,
    output logic                   m0AckOut,
    output logic                   m0ErrOut,
    output logic [BUS_WIDTH-1:0]   m0DatOut,

    input  logic                   m1CycIn,
    input  logic                   m1StbIn,
    input  logic                   m1WeIn,
    input  logic [31:0]            m1AdrIn,
    input  logic [BUS_WIDTH/8-1:0] m1SelIn,
    input  logic [BUS_WIDTH-1:0]   m1DatIn,
    output logic                   m1AckOut,
    output logic                   m1ErrOut,
    output logic [BUS_WIDTH-1:0]   m1DatOut,

    output logic                   cycOut,
    output logic                   stbOut,
    output logic                   weOut,
    output logic [31:0]            adrOut,
    output logic [BUS_WIDTH/8-1:0] selOut,
    output logic [BUS_WIDTH-1:0]   datOut,
    input  logic [BUS_WIDTH-1:0]   datIn,
    input  logic                   ackIn,
    input  logic                   errIn,

    output logic [1:0]             grant,
    output logic                   timeoutFlag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_e;

    state_e     state_q;
    logic       lastGnt_q;
    logic [1:0] grant_q;

    // Strobe of the current owner before the watchdog mask is applied.
    logic       stbRaw;
    logic       timeoutHit;

    // Ownership FSM. lastGnt_q resets to 1 so that master 0 wins the first
    // simultaneous request. On release the next owner is taken directly from
    // the other master's cyc; because the slave side mirrors the owner's cyc,
    // the release cycle itself already shows cycOut low to the slave.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lastGnt_q <= 1'b1;
            grant_q   <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0CycIn && (!m1CycIn || lastGnt_q)) begin
                        state_q   <= GNT0;
                        lastGnt_q <= 1'b0;
                        grant_q   <= 2'b01;
                    end else if (m1CycIn) begin
                        state_q   <= GNT1;
                        lastGnt_q <= 1'b1;
                        grant_q   <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0CycIn) begin
                        if (m1CycIn) begin
                            state_q   <= GNT1;
                            lastGnt_q <= 1'b1;
                            grant_q   <= 2'b10;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end
                end
                GNT1: begin
                    if (!m1CycIn) begin
                        if (m0CycIn) begin
                            state_q   <= GNT0;
                            lastGnt_q <= 1'b0;
                            grant_q   <= 2'b01;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign grant = grant_q;

    // Read data is broadcast; masters qualify it with their own ack.
    assign m0DatOut = datIn;
    assign m1DatOut = datIn;

    // Slave-side mux and termination routing. err has priority over ack,
    // and a watchdog expiry is reported as err while the strobe is masked.
    always_comb begin
        cycOut   = 1'b0;
        stbRaw   = 1'b0;
        weOut    = 1'b0;
        adrOut   = '0;
        selOut   = '0;
        datOut   = '0;
        m0AckOut = 1'b0;
        m0ErrOut = 1'b0;
        m1AckOut = 1'b0;
        m1ErrOut = 1'b0;
        case (state_q)
            GNT0: begin
                cycOut   = m0CycIn;
                stbRaw   = m0StbIn;
                weOut    = m0WeIn;
                adrOut   = m0AdrIn;
                selOut   = m0SelIn;
                datOut   = m0DatIn;
                m0AckOut = ackIn && !errIn && !timeoutHit;
                m0ErrOut = errIn || timeoutHit;
            end
            GNT1: begin
                cycOut   = m1CycIn;
                stbRaw   = m1StbIn;
                weOut    = m1WeIn;
                adrOut   = m1AdrIn;
                selOut   = m1SelIn;
                datOut   = m1DatIn;
                m1AckOut = ackIn && !errIn && !timeoutHit;
                m1ErrOut = errIn || timeoutHit;
            end
            default: begin
            end
        endcase
    end

    assign stbOut = stbRaw && !timeoutHit;

`ifdef RMAP_WB_ARB_TIMEOUT_EN
    logic [15:0] wdCount_q;
    logic [15:0] wdCount_d;

    assign timeoutHit = (wdCount_q == 16'(TIMEOUT_CYCLES));

    // Counts consecutive stalled strobe cycles; any termination, a dropped
    // strobe or the expiry itself starts the count over.
    always_comb begin
        wdCount_d = '0;
        if (!timeoutHit && stbRaw && !ackIn && !errIn) begin
            wdCount_d = wdCount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdCount_q <= '0;
        end else begin
            wdCount_q <= wdCount_d;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    assign timeoutFlag = timeoutHit;

endmodule

// File: tb/tb_rmap_wb_arbiter.sv
// tb_rmap_wb_arbiter
//
// Directed bench for rmap_wb_arbiter. A cycle-by-cycle vector table covers
// the simultaneous-request start, round-robin alternation, handover gaps and
// ack/err priority; hand-written sequences cover reset, a single request,
// the watchdog (both builds of RMAP_WB_ARB_TIMEOUT_EN) and reset mid-access.

module tb_rmap_wb_arbiter;

    localparam int BW = 32;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    localparam logic [3:0]  SEL0 = 4'h3;
    localparam logic [31:0] DAT0 = 32'h1111_0000;
    localparam logic [3:0]  SEL1 = 4'hC;
    localparam logic [31:0] DAT1 = 32'h2222_0000;

    logic clk = 1'b0;
    logic rst;

    logic          m0CycIn, m0StbIn, m0WeIn;
    logic [31:0]   m0AdrIn;
    logic [3:0]    m0SelIn;
    logic [BW-1:0] m0DatIn;
    logic          m0AckOut, m0ErrOut;
    logic [BW-1:0] m0DatOut;
    logic          m1CycIn, m1StbIn, m1WeIn;
    logic [31:0]   m1AdrIn;
    logic [3:0]    m1SelIn;
    logic [BW-1:0] m1DatIn;
    logic          m1AckOut, m1ErrOut;
    logic [BW-1:0] m1DatOut;
    logic          cycOut, stbOut, weOut;
    logic [31:0]   adrOut;
    logic [3:0]    selOut;
    logic [BW-1:0] datOut;
    logic [BW-1:0] datIn;
    logic          ackIn, errIn;
    logic [1:0]    grant;
    logic          timeoutFlag;

    int checks   = 0;
    int failures = 0;

    rmap_wb_arbiter #(
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m0CycIn     (m0CycIn),
        .m0StbIn     (m0StbIn),
        .m0WeIn      (m0WeIn),
        .m0AdrIn     (m0AdrIn),
        .m0SelIn     (m0SelIn),
        .m0DatIn     (m0DatIn),
        .m0AckOut    (m0AckOut),
        .m0ErrOut    (m0ErrOut),
        .m0DatOut    (m0DatOut),
        .m1CycIn     (m1CycIn),
        .m1StbIn     (m1StbIn),
        .m1WeIn      (m1WeIn),
        .m1AdrIn     (m1AdrIn),
        .m1SelIn     (m1SelIn),
        .m1DatIn     (m1DatIn),
        .m1AckOut    (m1AckOut),
        .m1ErrOut    (m1ErrOut),
        .m1DatOut    (m1DatOut),
        .cycOut      (cycOut),
        .stbOut      (stbOut),
        .weOut       (weOut),
        .adrOut      (adrOut),
        .selOut      (selOut),
        .datOut      (datOut),
        .datIn       (datIn),
        .ackIn       (ackIn),
        .errIn       (errIn),
        .grant       (grant),
        .timeoutFlag (timeoutFlag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        c0, s0, w0;
        logic [31:0] a0;
        logic        c1, s1, w1;
        logic [31:0] a1;
        logic        ack, err;
        logic [1:0]  eGrant;
        logic        eCyc, eStb, eWe;
        logic [31:0] eAdr;
        logic        eAck0, eErr0, eAck1, eErr1;
    } vec_t;

    vec_t vecs[14];

    // Packs the single-bit status outputs into one comparable word.
    function automatic logic [95:0] ctlWord();
        return 96'({grant, cycOut, stbOut, weOut,
                    m0AckOut, m0ErrOut, m1AckOut, m1ErrOut, timeoutFlag});
    endfunction

    task automatic checkOutput(input string name, input logic [95:0] act,
                               input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input logic [31:0] sdat);
        m0CycIn = v.c0; m0StbIn = v.s0; m0WeIn = v.w0; m0AdrIn = v.a0;
        m1CycIn = v.c1; m1StbIn = v.s1; m1WeIn = v.w1; m1AdrIn = v.a1;
        ackIn   = v.ack; errIn = v.err; datIn = sdat;
    endtask

    task automatic idleInputs();
        m0CycIn = 0; m0StbIn = 0; m0WeIn = 0; m0AdrIn = '0;
        m1CycIn = 0; m1StbIn = 0; m1WeIn = 0; m1AdrIn = '0;
        ackIn = 0; errIn = 0; datIn = '0;
    endtask

    // Advance to just after the next active edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_time_limit actual=expired required=finished");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        logic [31:0] expSel, expDat;
        int ack0Cnt, ack1Cnt, errCnt, flagCnt, firstErr, stbLowCnt;
        logic stbAtHit, stbAfter;

        m0SelIn = SEL0; m0DatIn = DAT0;
        m1SelIn = SEL1; m1DatIn = DAT1;
        idleInputs();

        vecs[0]  = '{H,H,H,32'h100, H,H,L,32'h200, L,L, 2'b00,L,L,L,32'h0,   L,L,L,L};
        vecs[1]  = '{H,H,H,32'h100, H,H,L,32'h200, L,L, 2'b01,H,H,H,32'h100, L,L,L,L};
        vecs[2]  = '{H,H,H,32'h100, H,H,L,32'h200, H,L, 2'b01,H,H,H,32'h100, H,L,L,L};
        vecs[3]  = '{L,L,H,32'h100, H,H,L,32'h200, L,L, 2'b01,L,L,H,32'h100, L,L,L,L};
        vecs[4]  = '{H,H,H,32'h100, H,H,L,32'h200, L,L, 2'b10,H,H,L,32'h200, L,L,L,L};
        vecs[5]  = '{H,H,H,32'h100, H,H,L,32'h200, H,L, 2'b10,H,H,L,32'h200, L,L,H,L};
        vecs[6]  = '{H,H,H,32'h100, L,L,L,32'h200, L,L, 2'b10,L,L,L,32'h200, L,L,L,L};
        vecs[7]  = '{H,H,H,32'h100, H,H,L,32'h200, L,L, 2'b01,H,H,H,32'h100, L,L,L,L};
        vecs[8]  = '{H,H,H,32'h100, H,H,L,32'h200, H,H, 2'b01,H,H,H,32'h100, L,H,L,L};
        vecs[9]  = '{L,L,H,32'h100, H,H,L,32'h200, L,L, 2'b01,L,L,H,32'h100, L,L,L,L};
        vecs[10] = '{H,H,H,32'h100, H,H,L,32'h200, L,L, 2'b10,H,H,L,32'h200, L,L,L,L};
        vecs[11] = '{H,H,H,32'h100, H,H,L,32'h200, L,H, 2'b10,H,H,L,32'h200, L,L,L,H};
        vecs[12] = '{L,L,H,32'h100, L,L,L,32'h200, L,L, 2'b10,L,L,L,32'h200, L,L,L,L};
        vecs[13] = '{L,L,H,32'h100, L,L,L,32'h200, H,L, 2'b00,L,L,L,32'h0,   L,L,L,L};

        // Reset state, with a request and an ack present that must be ignored.
        rst = 1'b1;
        m0CycIn = 1; m0StbIn = 1; ackIn = 1;
        repeat (3) nextCycle();
        checkOutput("reset_ctl", ctlWord(), 96'h0);
        checkOutput("reset_bus", {adrOut, selOut, datOut, 28'h0}, 96'h0);
        idleInputs();
        rst = 1'b0;

        // Table: simultaneous start, alternation 0,1,0,1, ack/err priority.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], 32'hD000_0000 + 32'(i));
            #1;
            expSel = (vecs[i].eGrant == 2'b01) ? 32'(SEL0) :
                     (vecs[i].eGrant == 2'b10) ? 32'(SEL1) : 32'h0;
            expDat = (vecs[i].eGrant == 2'b01) ? DAT0 :
                     (vecs[i].eGrant == 2'b10) ? DAT1 : 32'h0;
            checkOutput($sformatf("vec%0d_ctl", i), ctlWord(),
                        96'({vecs[i].eGrant, vecs[i].eCyc, vecs[i].eStb, vecs[i].eWe,
                             vecs[i].eAck0, vecs[i].eErr0, vecs[i].eAck1, vecs[i].eErr1, 1'b0}));
            checkOutput($sformatf("vec%0d_bus", i), {adrOut, 28'(selOut), datOut},
                        {vecs[i].eAdr, expSel[27:0], expDat});
            checkOutput($sformatf("vec%0d_rdata", i), 96'({m0DatOut, m1DatOut}),
                        96'({32'hD000_0000 + 32'(i), 32'hD000_0000 + 32'(i)}));
            nextCycle();
        end

        // Single request from master 0, slave acks two cycles after grant.
        m0CycIn = 1; m0StbIn = 1; m0AdrIn = 32'h10;
        #1;
        checkOutput("single_idle_grant", 96'(grant), 96'(2'b00));
        nextCycle();
        #1;
        checkOutput("single_grant", 96'(grant), 96'(2'b01));
        checkOutput("single_adr", 96'(adrOut), 96'h10);
        ack0Cnt = 0; ack1Cnt = 0;
        for (int k = 0; k < 4; k++) begin
            ackIn = (k == 2);
            if (k == 3) begin
                m0CycIn = 0; m0StbIn = 0;
            end
            #1;
            ack0Cnt += int'(m0AckOut);
            ack1Cnt += int'(m1AckOut);
            nextCycle();
        end
        checkOutput("single_m0_ack_pulses", 96'(ack0Cnt), 96'd1);
        checkOutput("single_m1_ack_pulses", 96'(ack1Cnt), 96'd0);
        idleInputs();
        #1;
        checkOutput("single_back_idle", 96'(grant), 96'(2'b00));
        nextCycle();

        // Watchdog: master 0 strobes and the slave never answers.
        m0CycIn = 1; m0StbIn = 1; m0AdrIn = 32'h40;
        nextCycle();
        errCnt = 0; flagCnt = 0; firstErr = 0; stbLowCnt = 0;
        stbAtHit = 1'b1; stbAfter = 1'b0;
`ifdef RMAP_WB_ARB_TIMEOUT_EN
        for (int k = 1; k <= 12; k++) begin
            #1;
            if (m0ErrOut && firstErr == 0) firstErr = k;
            errCnt  += int'(m0ErrOut);
            flagCnt += int'(timeoutFlag);
            if (k == 9)  stbAtHit = stbOut;
            if (k == 10) stbAfter = stbOut;
            nextCycle();
        end
        checkOutput("wd_first_err_cycle", 96'(firstErr), 96'd9);
        checkOutput("wd_err_pulses", 96'(errCnt), 96'd1);
        checkOutput("wd_flag_pulses", 96'(flagCnt), 96'd1);
        checkOutput("wd_stb_masked", 96'(stbAtHit), 96'd0);
        checkOutput("wd_stb_restored", 96'(stbAfter), 96'd1);
`else
        for (int k = 1; k <= 100; k++) begin
            #1;
            errCnt    += int'(m0ErrOut);
            flagCnt   += int'(timeoutFlag);
            stbLowCnt += int'(!stbOut);
            nextCycle();
        end
        checkOutput("nowd_err_pulses", 96'(errCnt), 96'd0);
        checkOutput("nowd_flag_pulses", 96'(flagCnt), 96'd0);
        checkOutput("nowd_stb_low_cycles", 96'(stbLowCnt), 96'd0);
`endif
        idleInputs();
        nextCycle();
        nextCycle();

        // Reset asserted while master 1 owns the bus and the slave is acking.
        m1CycIn = 1; m1StbIn = 1; m1AdrIn = 32'h80;
        nextCycle();
        ackIn = 1;
        #1;
        checkOutput("mid_pre_ctl", ctlWord(), 96'({2'b10, 3'b110, 4'b0010, 1'b0}));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_ctl", ctlWord(), 96'h0);
        checkOutput("mid_reset_bus", {adrOut, selOut, datOut, 28'h0}, 96'h0);
        nextCycle();
        rst = 1'b0;
        idleInputs();
        m0CycIn = 1; m0StbIn = 1;
        m1CycIn = 1; m1StbIn = 1;
        #1;
        checkOutput("post_reset_idle", 96'(grant), 96'(2'b00));
        nextCycle();
        #1;
        checkOutput("post_reset_grant_m0", 96'(grant), 96'(2'b01));

        idleInputs();
        nextCycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
